branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/bru_pkg.sv | 31 +++
 rtl/bru_fifo.sv | 63 ++++++
 rtl/branch_resolve_unit.sv | 134 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit: 2-bit predictor counter
// encodings, the resolve FSM states and the saturating counter update.
package bru_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef enum logic {
    NORMAL = 1'b0,
    FLUSH  = 1'b1
  } bru_state_e;

  localparam int MISCNT_W = 16;

  // Move the counter one step toward the actual direction, saturating at the ends.
  function automatic ctr_e sat_update(input ctr_e s, input logic taken);
    ctr_e r;
    r = s;
    if (taken) begin
      if (s != ST) r = ctr_e'(s + 2'd1);
    end else begin
      if (s != SNT) r = ctr_e'(s - 2'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/bru_fifo.sv
// In-order prediction queue: DEPTH slots of W bits with push, pop and a
// synchronous flush that empties the queue and drops any same-cycle push.
module bru_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [W-1:0]           i_wdata,
  output logic [W-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  assign w_push = i_push & ~o_full & ~i_flush;
  assign w_pop  = i_pop & ~o_empty & ~i_flush;

  // Slot storage; written only on an accepted push.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  // Pointers wrap naturally at the power-of-two depth; flush empties the queue.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: queues fetch-time predictions, compares them with
// execute-stage resolutions, emits predictor-table updates and a one-cycle
// flush/redirect on a mispredict.
// Optional misprediction statistics counter: define BRU_STATS_EN.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = 4,
  parameter int PC_W  = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   pred_valid,
  output logic                   pred_ready,
  input  logic [IDX_W-1:0]       pred_idx,
  input  logic [1:0]             pred_state,
  input  logic [PC_W-1:0]        pred_target,
  input  logic                   res_valid,
  input  logic                   res_taken,
  input  logic [PC_W-1:0]        res_target,
  input  logic [PC_W-1:0]        res_fallthru,
  output logic                   upd_we,
  output logic [IDX_W-1:0]       upd_idx,
  output logic [1:0]             upd_state,
  output logic                   flush,
  output logic [PC_W-1:0]        redirect_pc,
  output logic [$clog2(DEPTH):0] count,
  output logic [MISCNT_W-1:0]    mispred_cnt
);

  localparam int ENT_W = IDX_W + 2 + PC_W;

  bru_state_e       r_state;
  bru_state_e       w_state_next;
  logic [ENT_W-1:0] w_head;
  logic [IDX_W-1:0] w_head_idx;
  logic [1:0]       w_head_state;
  logic [PC_W-1:0]  w_head_tgt;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_mis;
  logic             r_upd_we;
  logic [IDX_W-1:0] r_upd_idx;
  ctr_e             r_upd_state;
  logic             r_flush;
  logic [PC_W-1:0]  r_redirect;

  // Readiness ignores a same-cycle pop, so a full queue never takes a push.
  assign pred_ready = (r_state == NORMAL) & ~w_full;
  assign w_push     = pred_valid & pred_ready;
  assign w_pop      = res_valid & ~w_empty & (r_state == NORMAL);

  assign w_head_idx   = w_head[ENT_W-1 -: IDX_W];
  assign w_head_state = w_head[PC_W +: 2];
  assign w_head_tgt   = w_head[PC_W-1:0];

  assign w_mis = w_pop & ((w_head_state[1] != res_taken) |
                          (res_taken & (w_head_tgt != res_target)));

  bru_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_mis),
    .i_wdata ({pred_idx, pred_state, pred_target}),
    .o_rdata (w_head),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= NORMAL;
    else      r_state <= w_state_next;
  end

  // Next state: a mispredict costs exactly one FLUSH cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      NORMAL:  if (w_mis) w_state_next = FLUSH;
      FLUSH:   w_state_next = NORMAL;
      default: w_state_next = NORMAL;
    endcase
  end

  // Registered update strobe, flush pulse and held redirect address.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_upd_we    <= 1'b0;
      r_upd_idx   <= '0;
      r_upd_state <= SNT;
      r_flush     <= 1'b0;
      r_redirect  <= '0;
    end else begin
      r_upd_we <= w_pop;
      r_flush  <= w_mis;
      if (w_pop) begin
        r_upd_idx   <= w_head_idx;
        r_upd_state <= sat_update(ctr_e'(w_head_state), res_taken);
      end
      if (w_mis) r_redirect <= res_taken ? res_target : res_fallthru;
    end
  end

  assign upd_we      = r_upd_we;
  assign upd_idx     = r_upd_idx;
  assign upd_state   = r_upd_state;
  assign flush       = r_flush;
  assign redirect_pc = r_redirect;

`ifdef BRU_STATS_EN
  logic [MISCNT_W-1:0] r_mispred_cnt;

  // Saturating misprediction counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                             r_mispred_cnt <= '0;
    else if (w_mis && r_mispred_cnt != '1) r_mispred_cnt <= r_mispred_cnt + 1'b1;
  end

  assign mispred_cnt = r_mispred_cnt;
`else
  assign mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: stimulus pushes hand-computed
// expected updates into a queue; a monitor pops and compares on each upd_we.
module tb_branch_resolve_unit;

  logic        CLK;
  logic        RST;
  logic        pred_valid;
  logic        pred_ready;
  logic [3:0]  pred_idx;
  logic [1:0]  pred_state;
  logic [31:0] pred_target;
  logic        res_valid;
  logic        res_taken;
  logic [31:0] res_target;
  logic [31:0] res_fallthru;
  logic        upd_we;
  logic [3:0]  upd_idx;
  logic [1:0]  upd_state;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [2:0]  count;
  logic [15:0] mispred_cnt;

  typedef struct packed {
    logic [3:0]  idx;
    logic [1:0]  st;
    logic        fl;
    logic [31:0] rpc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_mis    = 0;

  branch_resolve_unit #(
    .DEPTH (4),
    .IDX_W (4),
    .PC_W  (32)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .pred_valid   (pred_valid),
    .pred_ready   (pred_ready),
    .pred_idx     (pred_idx),
    .pred_state   (pred_state),
    .pred_target  (pred_target),
    .res_valid    (res_valid),
    .res_taken    (res_taken),
    .res_target   (res_target),
    .res_fallthru (res_fallthru),
    .upd_we       (upd_we),
    .upd_idx      (upd_idx),
    .upd_state    (upd_state),
    .flush        (flush),
    .redirect_pc  (redirect_pc),
    .count        (count),
    .mispred_cnt  (mispred_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_mis_cnt();
`ifdef BRU_STATS_EN
    return 16'(n_mis);
`else
    return 16'd0;
`endif
  endfunction

  task automatic expect_upd(input logic [3:0] idx, input logic [1:0] st,
                            input logic fl, input logic [31:0] rpc);
    exp_t e;
    e.idx = idx; e.st = st; e.fl = fl; e.rpc = rpc;
    exp_q.push_back(e);
    if (fl) n_mis++;
  endtask

  task automatic step(input logic pv, input logic [3:0] pi, input logic [1:0] ps,
                      input logic [31:0] pt, input logic rv, input logic rt,
                      input logic [31:0] rtg, input logic [31:0] rft);
    pred_valid = pv; pred_idx = pi; pred_state = ps; pred_target = pt;
    res_valid = rv; res_taken = rt; res_target = rtg; res_fallthru = rft;
    @(posedge CLK); #1;
    pred_valid = 1'b0;
    res_valid  = 1'b0;
  endtask

  task automatic push(input logic [3:0] i, input logic [1:0] s, input logic [31:0] t);
    step(1'b1, i, s, t, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic resolve(input logic rt, input logic [31:0] rtg, input logic [31:0] rft);
    step(1'b0, 4'h0, 2'b00, 32'h0, 1'b1, rt, rtg, rft);
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Monitor: compare every update against the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST === 1'b1) begin
        if (upd_we) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_upd_we", upd_we, 1'b0);
          end else begin
            e = exp_q.pop_front();
            chk("upd_idx", upd_idx, e.idx);
            chk("upd_state", upd_state, e.st);
            chk("flush", flush, e.fl);
            if (e.fl) chk("redirect_pc", redirect_pc, e.rpc);
          end
        end else begin
          chk("flush_without_update", flush, 1'b0);
        end
      end
    end
  end

  initial begin
    pred_valid = 0; pred_idx = 0; pred_state = 0; pred_target = 0;
    res_valid = 0; res_taken = 0; res_target = 0; res_fallthru = 0;
    RST = 1'b1;
    #1 RST = 1'b0;
    #1;
    chk("rst_count", count, 3'd0);
    chk("rst_upd_we", upd_we, 1'b0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_redirect", redirect_pc, 32'h0);
    chk("rst_mispred", mispred_cnt, 16'h0);
    chk("rst_ready", pred_ready, 1'b1);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;

    // Weakly not-taken, resolved taken: direction mispredict.
    push(4'd3, 2'b01, 32'h100);
    chk("a_count1", count, 3'd1);
    expect_upd(4'd3, 2'b10, 1'b1, 32'h100);
    resolve(1'b1, 32'h100, 32'h204);
    chk("a_count0", count, 3'd0);
    chk("a_ready_flush", pred_ready, 1'b0);
    idle();
    chk("a_ready_back", pred_ready, 1'b1);

    // Strongly taken, correct target: no flush, counter saturates.
    push(4'd5, 2'b11, 32'h200);
    expect_upd(4'd5, 2'b11, 1'b0, 32'h0);
    resolve(1'b1, 32'h200, 32'h304);
    chk("b_count0", count, 3'd0);
    chk("b_ready", pred_ready, 1'b1);
    chk("b_redirect_hold", redirect_pc, 32'h100);

    // Fill to DEPTH, reject a fifth push, pop+push while full.
    push(4'd1, 2'b10, 32'h300);
    push(4'd2, 2'b00, 32'h304);
    push(4'd6, 2'b11, 32'h308);
    chk("c_count3", count, 3'd3);
    push(4'd7, 2'b01, 32'h30C);
    chk("c_count4", count, 3'd4);
    chk("c_full_ready", pred_ready, 1'b0);
    push(4'd8, 2'b11, 32'h310);
    chk("c_fifth_rejected", count, 3'd4);
    expect_upd(4'd1, 2'b11, 1'b0, 32'h0);
    step(1'b1, 4'd9, 2'b11, 32'h314, 1'b1, 1'b1, 32'h300, 32'h0);
    chk("c_poppush_full", count, 3'd3);
    expect_upd(4'd2, 2'b00, 1'b0, 32'h0);
    resolve(1'b0, 32'h0, 32'h308);
    expect_upd(4'd6, 2'b11, 1'b0, 32'h0);
    resolve(1'b1, 32'h308, 32'h30C);
    expect_upd(4'd7, 2'b00, 1'b0, 32'h0);
    resolve(1'b0, 32'h0, 32'h310);
    chk("c_drained", count, 3'd0);

    // Three queued, head 10 resolved not-taken with a same-cycle push.
    push(4'd4, 2'b10, 32'h400);
    push(4'd5, 2'b01, 32'h404);
    push(4'd6, 2'b01, 32'h408);
    chk("d_count3", count, 3'd3);
    expect_upd(4'd4, 2'b01, 1'b1, 32'h504);
    step(1'b1, 4'd9, 2'b00, 32'h40C, 1'b1, 1'b0, 32'h400, 32'h504);
    chk("d_count0", count, 3'd0);
    chk("d_ready_flush", pred_ready, 1'b0);
    idle();
    chk("d_ready_back", pred_ready, 1'b1);
    chk("d_push_dropped", count, 3'd0);

    // Resolve with an empty queue is ignored.
    resolve(1'b1, 32'h123, 32'h456);
    chk("e_upd_we", upd_we, 1'b0);
    chk("e_flush", flush, 1'b0);
    chk("e_mispred", mispred_cnt, exp_mis_cnt());

    // Target mispredict on a strongly-taken entry.
    push(4'd2, 2'b11, 32'h600);
    expect_upd(4'd2, 2'b11, 1'b1, 32'h700);
    resolve(1'b1, 32'h700, 32'h604);
    idle();
    chk("f_mispred3", mispred_cnt, exp_mis_cnt());

    // Reset mid-operation: two queued, a mispredicting resolve pending.
    push(4'd1, 2'b11, 32'h800);
    push(4'd2, 2'b00, 32'h804);
    push(4'd3, 2'b00, 32'h808);
    expect_upd(4'd1, 2'b11, 1'b0, 32'h0);
    resolve(1'b1, 32'h800, 32'h804);
    chk("g_count2", count, 3'd2);
    res_valid = 1'b1; res_taken = 1'b1; res_target = 32'h999; res_fallthru = 32'h808;
    @(negedge CLK); #1;
    RST = 1'b0;
    #1;
    n_mis = 0;
    chk("g_upd_we", upd_we, 1'b0);
    chk("g_upd_idx", upd_idx, 4'd0);
    chk("g_upd_state", upd_state, 2'b00);
    chk("g_flush", flush, 1'b0);
    chk("g_redirect", redirect_pc, 32'h0);
    chk("g_count", count, 3'd0);
    chk("g_mispred", mispred_cnt, 16'h0);
    res_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    resolve(1'b1, 32'h804, 32'h808);
    idle();
    chk("g_count_after", count, 3'd0);
    chk("g_no_update", upd_we, 1'b0);

    idle();
    idle();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
